anode_scanner: RTL and testbench

Time-multiplexing driver for the 8-digit seven-segment display. It generates the active-low `anode_select` one-hot-low scan that the digit decoder consumes. It also latches a tear-free copy of the displayed 32-bit value once per frame. Between digits it inserts a programmable blanking gap to suppress ghosting. It sits between the value source (counter, register file) and the digit/segment decode path.

---
 rtl/seven_seg_pkg.sv | 9 +
 rtl/anode_scanner_slot_timer.sv | 22 ++
 rtl/anode_scanner.sv | 74 +++++++
 tb/tb_anode_scanner.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and types for the seven-segment display path
// Contents: digit count, all-anodes-off pattern, digit index type, scan FSM states
package seven_seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;
    typedef logic [2:0] digit_idx_t;
    localparam digit_idx_t LAST_DIGIT = 3'(NUM_DIGITS - 1);
    typedef enum logic {IDLE, SCAN} scan_state_t;
endpackage

// File: rtl/anode_scanner_slot_timer.sv
// slot_timer: counts clk cycles within one digit slot and flags the last one
// Ports: clk, rst (async, active-high), clear (sync restart at 0),
//        cnt (0..DIV-1), slot_end (high while cnt == DIV-1)
module slot_timer #(
    parameter int DIV = 100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    output logic [$clog2(DIV)-1:0] cnt,
    output logic                   slot_end
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] r_cnt;
    assign cnt      = r_cnt;
    assign slot_end = r_cnt == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= (clear || slot_end) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/anode_scanner.sv
// anode_scanner: time-multiplexed active-low anode scan for an 8-digit display
// Ports: clk, rst (async, active-high), en (scan enable),
//        digit_mask (per-digit enable), value_in (nibble k -> digit k),
//        anode_select (active-low one-hot-low, FF = off),
//        value_out (value latched once per frame), frame_start (first cycle of slot 0)
module anode_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIV          = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  digit_mask,
    input  logic [31:0] value_in,
    output logic [7:0]  anode_select,
    output logic [31:0] value_out,
    output logic        frame_start
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    scan_state_t   r_state;
    digit_idx_t    r_idx;
    logic [7:0]    r_mask;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_nxt;
    digit_idx_t    w_idx_nxt;
    logic [7:0]    w_mask;
    logic          w_slot_end;
    logic          w_idle;
    logic          w_first;
    logic          w_blank;
    logic          w_lit;
    assign w_idle = r_state == IDLE;
    slot_timer #(.DIV(DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_idle || !en),
        .cnt      (w_cnt),
        .slot_end (w_slot_end)
    );
    // Outputs are registered, so decode from the position the next edge moves to.
    assign w_cnt_nxt = (w_idle || w_slot_end) ? '0 : w_cnt + 1'b1;
    assign w_idx_nxt = w_idle ? '0 : (w_slot_end ? r_idx + 3'd1 : r_idx);
    assign w_first   = en && (w_idle || (w_slot_end && r_idx == LAST_DIGIT));
    // The mask latched on a frame's first edge must already gate that edge's anode.
    assign w_mask    = w_first ? digit_mask : r_mask;
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = w_cnt_nxt < BLANK;
        end
    endgenerate
    assign w_lit = en && !w_blank && w_mask[w_idx_nxt];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_mask       <= '0;
            value_out    <= '0;
            frame_start  <= 1'b0;
            anode_select <= ANODE_OFF;
        end else begin
            r_state      <= en ? SCAN : IDLE;
            r_idx        <= en ? w_idx_nxt : '0;
            r_mask       <= w_mask;
            frame_start  <= w_first;
            anode_select <= w_lit ? ~(8'd1 << w_idx_nxt) : ANODE_OFF;
            if (w_first) value_out <= value_in;
        end
    end
endmodule

// File: tb/tb_anode_scanner.sv
// tb_anode_scanner: directed self-checking bench for anode_scanner (DIV=8, blank 2 and 0)
module tb_anode_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  digit_mask;
    logic [31:0] value_in;
    logic [7:0]  anode_select;
    logic [31:0] value_out;
    logic        frame_start;
    logic [7:0]  anode_b0;
    logic [31:0] value_out_b0;
    logic        frame_start_b0;
    int          errs = 0;
    int          checks = 0;

    anode_scanner #(.DIV(8), .BLANK_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .digit_mask   (digit_mask),
        .value_in     (value_in),
        .anode_select (anode_select),
        .value_out    (value_out),
        .frame_start  (frame_start)
    );

    anode_scanner #(.DIV(8), .BLANK_CYCLES(0)) dut_b0 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .digit_mask   (digit_mask),
        .value_in     (value_in),
        .anode_select (anode_b0),
        .value_out    (value_out_b0),
        .frame_start  (frame_start_b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_anode(input int n, input logic [7:0] m, input int b);
        int s = (n / 8) % 8;
        int c = n % 8;
        logic [7:0] oh = 8'd1 << s;
        return (c < b || !m[s]) ? 8'hFF : ~oh;
    endfunction

    // n counts edges since the frame-0 entry edge; slot = n/8, cycle = n%8
    task automatic scan_check(input int n, input logic [7:0] m, input logic [31:0] v);
        chk("anode", anode_select, exp_anode(n, m, 2));
        chk("anode_b0", anode_b0, exp_anode(n, m, 0));
        chk("frame_start", frame_start, (n % 64) == 0);
        chk("value_out", value_out, v);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        digit_mask = 8'hFF;
        value_in = 32'h1234_5678;
        #2;
        chk("rst_anode", anode_select, 8'hFF);
        chk("rst_value", value_out, 32'h0);
        chk("rst_frame", frame_start, 1'b0);
        tick;
        tick;
        chk("idle_anode", anode_select, 8'hFF);
        rst = 1'b0;
        en = 1'b1;
        for (int n = 0; n <= 171; n++) begin
            tick;
            scan_check(n, (n < 64 || n >= 128) ? 8'hFF : 8'h05,
                       (n < 64) ? 32'h1234_5678 : 32'hDEAD_BEEF);
            if (n == 24) value_in = 32'hDEAD_BEEF;
            if (n == 30) digit_mask = 8'h05;
            if (n == 100) digit_mask = 8'hFF;
        end
        chk("slot5_lit", anode_select, 8'hDF);
        en = 1'b0;
        tick;
        chk("dis_anode", anode_select, 8'hFF);
        chk("dis_anode_b0", anode_b0, 8'hFF);
        chk("dis_frame", frame_start, 1'b0);
        chk("dis_value", value_out, 32'hDEAD_BEEF);
        value_in = 32'hCAFE_F00D;
        tick;
        chk("idle2_anode", anode_select, 8'hFF);
        chk("idle2_value", value_out, 32'hDEAD_BEEF);
        en = 1'b1;
        for (int n = 0; n <= 19; n++) begin
            tick;
            scan_check(n, 8'hFF, 32'hCAFE_F00D);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_anode", anode_select, 8'hFF);
        chk("arst_anode_b0", anode_b0, 8'hFF);
        chk("arst_value", value_out, 32'h0);
        chk("arst_frame", frame_start, 1'b0);
        tick;
        rst = 1'b0;
        en = 1'b0;
        tick;
        chk("post_rst_anode", anode_select, 8'hFF);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
